// File: rtl/rvv_trap_drain_if.sv
// Trap/drain handshake bundle between the scalar trap port, backend status flags and the drain controller.
interface rvv_trap_drain_if #(
   parameter int unsigned NUM_RT_UOP = 4,
   parameter int unsigned ISSUE_LANE = 2,
   parameter int unsigned VCSR_W     = 64
);
   logic                                 trap_valid_rvs2rvv;
   logic                                 trap_ready_rvv2rvs;
   logic                                 cmdq_stall;
   logic [ISSUE_LANE-1:0]                cmdq_push;
   logic                                 cmd_q_empty;
   logic                                 uop_q_empty;
   logic                                 alu_rs_empty;
   logic                                 mul_rs_empty;
   logic                                 div_rs_empty;
   logic                                 pmtrdt_rs_empty;
   logic                                 lsu_rs_empty;
   logic                                 rob_empty;
   logic [NUM_RT_UOP-1:0]                rob2rt_write_valid;
   logic [NUM_RT_UOP-1:0]                rt2rob_write_ready;
   logic [NUM_RT_UOP-1:0][VCSR_W-1:0]    rob2rt_vcsr;
   logic                                 vcsr_valid;
   logic                                 vcsr_ready;
   logic [VCSR_W-1:0]                    vcsr_data;
   logic                                 drain_timeout;

   modport master (
      output trap_valid_rvs2rvv, cmdq_push, cmd_q_empty, uop_q_empty,
             alu_rs_empty, mul_rs_empty, div_rs_empty, pmtrdt_rs_empty, lsu_rs_empty,
             rob_empty, rob2rt_write_valid, rt2rob_write_ready, rob2rt_vcsr, vcsr_ready,
      input  trap_ready_rvv2rvs, cmdq_stall, vcsr_valid, vcsr_data, drain_timeout
   );

   modport slave (
      input  trap_valid_rvs2rvv, cmdq_push, cmd_q_empty, uop_q_empty,
             alu_rs_empty, mul_rs_empty, div_rs_empty, pmtrdt_rs_empty, lsu_rs_empty,
             rob_empty, rob2rt_write_valid, rt2rob_write_ready, rob2rt_vcsr, vcsr_ready,
      output trap_ready_rvv2rvs, cmdq_stall, vcsr_valid, vcsr_data, drain_timeout
   );
endinterface

// File: rtl/rvv_trap_drain_ctrl.sv
// Drains the RVV backend on a scalar trap request, acknowledges the trap, then
// offers the vcsr of the youngest retired uop back to the scalar side.
module rvv_trap_drain_ctrl #(
   parameter int unsigned NUM_RT_UOP    = 4,
   parameter int unsigned ISSUE_LANE    = 2,
   parameter int unsigned VCSR_W        = 64,
   parameter int unsigned DRAIN_TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              rst,
   rvv_trap_drain_if.slave   trap_if
);
   localparam int unsigned CNT_W = $clog2(DRAIN_TIMEOUT) + 1;

   typedef enum logic [1:0] {IDLE, DRAIN, ACK, VCSR} state_e;

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      drain_cnt_q, drain_cnt_d;
   logic [VCSR_W-1:0]     vcsr_cap_q, vcsr_cap_d;
   logic                  timeout_q, timeout_d;
   logic                  stall_q, trap_ready_q, vcsr_valid_q;

   logic [ISSUE_LANE-1:0] push;
   logic [NUM_RT_UOP-1:0] rt_fire;
   logic                  any_fire;
   logic                  all_empty;
   logic                  idle_ok;
   logic [VCSR_W-1:0]     youngest_vcsr;

   assign push     = trap_if.cmdq_push;
   assign rt_fire  = trap_if.rob2rt_write_valid & trap_if.rt2rob_write_ready;
   assign any_fire = |rt_fire;

   assign all_empty = trap_if.cmd_q_empty  & trap_if.uop_q_empty  &
                      trap_if.alu_rs_empty & trap_if.mul_rs_empty &
                      trap_if.div_rs_empty & trap_if.pmtrdt_rs_empty &
                      trap_if.lsu_rs_empty & trap_if.rob_empty;

   // A push or a retire in flight means something is still moving through the backend.
   assign idle_ok = all_empty & (push == '0) & ~any_fire;

   // Ascending scan: the last (highest-index, youngest) firing lane wins.
   always_comb begin
      youngest_vcsr = '0;
      for (int unsigned i = 0; i < NUM_RT_UOP; i++) begin
         if (rt_fire[i]) youngest_vcsr = trap_if.rob2rt_vcsr[i];
      end
   end

   // Next-state, drain counter, timeout and vcsr capture.
   always_comb begin
      state_d     = state_q;
      drain_cnt_d = drain_cnt_q;
      vcsr_cap_d  = vcsr_cap_q;
      timeout_d   = timeout_q;

      case (state_q)
         IDLE: begin
            if (trap_if.trap_valid_rvs2rvv) begin
               state_d     = DRAIN;
               drain_cnt_d = '0;
            end
         end
         DRAIN: begin
            if (idle_ok) begin
               state_d = ACK;
            end else begin
               if (drain_cnt_q != CNT_W'(DRAIN_TIMEOUT)) drain_cnt_d = drain_cnt_q + CNT_W'(1);
               if (drain_cnt_d == CNT_W'(DRAIN_TIMEOUT - 1)) timeout_d = 1'b1;
            end
         end
         ACK:     state_d = VCSR;
         VCSR: begin
            if (trap_if.vcsr_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Capture freezes once the trap is acknowledged so the offered vcsr stays stable.
      if (((state_q == IDLE) || (state_q == DRAIN)) && any_fire) vcsr_cap_d = youngest_vcsr;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         drain_cnt_q  <= '0;
         vcsr_cap_q   <= '0;
         timeout_q    <= 1'b0;
         stall_q      <= 1'b0;
         trap_ready_q <= 1'b0;
         vcsr_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         drain_cnt_q  <= drain_cnt_d;
         vcsr_cap_q   <= vcsr_cap_d;
         timeout_q    <= timeout_d;
         stall_q      <= (state_d != IDLE);
         trap_ready_q <= (state_d == ACK);
         vcsr_valid_q <= (state_d == VCSR);
      end
   end

   assign trap_if.cmdq_stall         = stall_q;
   assign trap_if.trap_ready_rvv2rvs = trap_ready_q;
   assign trap_if.vcsr_valid         = vcsr_valid_q;
   assign trap_if.vcsr_data          = vcsr_cap_q;
   assign trap_if.drain_timeout      = timeout_q;
endmodule
